sync_ctrl: RTL and testbench
============================

# sync_ctrl

Sequencing controller for the analyzer's input-synchronizer stage. It accepts configuration commands from the command decoder over a valid/ready handshake, holds the filter, demux and edge-select flags that drive the input stage, and arms or disarms capture. While running it generates a divided sample strobe. After every arm or flag change it blanks that strobe until the input-stage pipeline has flushed stale data.

## Interface
Parameters:
- `DIV_WIDTH`, default 24: width of the sample-rate divider register and counter.
- `SETTLE_CYCLES`, default 3: cycles of strobe blanking after arm or flag change; legal range 1..15.

Ports:
- `clock` in, 1: single clock for the whole block. Reset is asynchronous and active-low.
- `resetn` in, 1: asynchronous active-low reset.
- `cmd_valid` in, 1: a command is offered.
- `cmd_ready` out, 1: the block can accept a command.
- `cmd_op` in, 2: opcode. 0 = write flags, 1 = write divider, 2 = arm, 3 = disarm.
- `cmd_data` in, 32: payload.
  - Flags: bit0 = `falling`, bit1 = `enableFilter`, bit2 = `enableDemux`.
  - Divider: bits `[DIV_WIDTH-1:0]`.
- `enableFilter` out, 1: to input stage.
- `enableDemux` out, 1: to input stage.
- `falling` out, 1: to input stage.
- `run` out, 1: capture armed (state is SETTLE or RUN).
- `sample_valid` out, 1: one-cycle strobe; the input-stage output is a valid sample this cycle.
- `busy` out, 1: state is SETTLE.

## Operation
- States:
  - IDLE: not armed.
  - SETTLE: blanking after arm or flag change.
  - RUN: armed, strobes enabled.
- Handshake:
  - `cmd_ready` = (state != SETTLE), decoded combinationally from the state register.
  - A command is accepted on a cycle with `cmd_valid` && `cmd_ready`.
  - `cmd_op`/`cmd_data` are ignored when not accepted.
- Write flags (op 0):
  - The three flag outputs take `cmd_data[2:0]` on the next edge, in any state.
  - In RUN, if the new value differs from the current flags, go to SETTLE. An identical value stays in RUN with no blanking.
  - In IDLE, stay in IDLE.
- Write divider (op 1):
  - Loads the divider register and clears the sample counter.
  - No state change and no settle.
- Arm (op 2):
  - From IDLE, go to SETTLE.
  - From RUN, ignored; counter and strobe are unaffected.
- Disarm (op 3):
  - Go to IDLE from any accepting state. `sample_valid` is 0 from the next cycle.
- SETTLE:
  - The settle counter loads `SETTLE_CYCLES-1` on entry and decrements each cycle.
  - At 0, go to RUN with the sample counter cleared.
  - Lasts exactly `SETTLE_CYCLES` cycles.
  - Commands stall (`cmd_ready`=0), so disarm is impossible mid-settle.
- Divider in RUN:
  - The counter counts 0..div.
  - `sample_valid` is 1 in each cycle where the count equals div; the counter then wraps to 0.
  - div = 0 gives a strobe every RUN cycle.
  - The first strobe after entering RUN occurs in RUN cycle div+1.
- Flags with both demux and filter set are passed through unchanged; the input stage gives demux priority.

## Timing
- All outputs except `cmd_ready` are registered.
- Reset values:
  - state IDLE.
  - `enableFilter`, `enableDemux`, `falling` = 0.
  - divider = 0.
  - counters = 0.
  - `run`, `sample_valid`, `busy` = 0.
  - `cmd_ready` = 1.
- Latencies:
  - Accepted command to flag or `run` output change: 1 cycle.
  - Accepted arm to first `sample_valid`: `SETTLE_CYCLES` + div + 1 cycles.
- Reset asserted mid-SETTLE or mid-RUN returns all state to reset values immediately and asynchronously. Deassertion is synchronized externally.
- Counter wrap: the sample counter never exceeds the divider register. A divider write that lowers div below the current count is safe because the counter is cleared.

## Configuration
- Macro: `SYNC_CTRL_DIVIDER_EN`.
- Defined: divider register, sample counter and op 1 behave as above.
- Undefined:
  - No divider logic.
  - Op 1 is accepted with a normal handshake and otherwise ignored.
  - `sample_valid` = 1 on every RUN cycle, i.e. first strobe `SETTLE_CYCLES` + 1 cycles after arm.

## Structure
- Package `sync_ctrl_pkg`:
  - opcode constants `OP_FLAGS`, `OP_DIV`, `OP_ARM`, `OP_DISARM`.
  - state enum IDLE/SETTLE/RUN.
  - flag bit-position constants `FLG_FALLING`, `FLG_FILTER`, `FLG_DEMUX`.
- Sub-module `sample_divider`:
  - Contains the `DIV_WIDTH` counter, compare and strobe register.
  - Inputs: enable (state == RUN), clear, div.
  - Instantiated only under `SYNC_CTRL_DIVIDER_EN`.

## Test plan
- Reset, then arm with div=0 and `SETTLE_CYCLES`=3 -> `run`=1 next cycle, `busy`=1 for 3 cycles, `sample_valid` high on every cycle from cycle 4.
- Divider write 4, then arm -> strobes exactly every 5 cycles; first strobe 3+5 cycles after arm.
- In RUN, flags write 3'b010 -> `enableFilter`=1 next cycle, `busy`=1 and `sample_valid`=0 for 3 cycles, `cmd_ready`=0 during settle, then strobes resume.
- In RUN, flags write equal to the current value -> no settle, strobe cadence unbroken.
- `cmd_valid` held during SETTLE with disarm -> accepted only on the first cycle after settle ends; `sample_valid`=0 thereafter.
- `resetn` pulsed low mid-RUN with div=7 -> all outputs 0 and `cmd_ready`=1 immediately; flags and divider back to 0.

Source files
------------

// File: rtl/sync_ctrl_pkg.sv
// Shared opcodes, flag bit positions and sequencing states for the sync_ctrl block.
package sync_ctrl_pkg;

    localparam logic [1:0] OP_FLAGS  = 2'd0;
    localparam logic [1:0] OP_DIV    = 2'd1;
    localparam logic [1:0] OP_ARM    = 2'd2;
    localparam logic [1:0] OP_DISARM = 2'd3;

    localparam int FLG_FALLING = 0;
    localparam int FLG_FILTER  = 1;
    localparam int FLG_DEMUX   = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

endpackage

// File: rtl/sample_divider.sv
// Sample-rate divider: counts 0..div while enabled and registers a one-cycle strobe at div.
module sample_divider #(
    parameter int DIV_WIDTH = 24
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 strobe
);

    logic [DIV_WIDTH-1:0] cnt_r;
    logic [DIV_WIDTH-1:0] cnt_eff_s;
    logic                 strobe_r;

    // A clear makes the following cycle count as position 0 against the new divider.
    assign cnt_eff_s = clear ? {DIV_WIDTH{1'b0}} : cnt_r;
    assign strobe    = strobe_r;

    // Counter and strobe register; held at zero whenever the next cycle is not a RUN cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_r    <= {DIV_WIDTH{1'b0}};
            strobe_r <= 1'b0;
        end else if (!enable) begin
            cnt_r    <= {DIV_WIDTH{1'b0}};
            strobe_r <= 1'b0;
        end else if (cnt_eff_s == div) begin
            cnt_r    <= {DIV_WIDTH{1'b0}};
            strobe_r <= 1'b1;
        end else begin
            cnt_r    <= cnt_eff_s + DIV_WIDTH'(1);
            strobe_r <= 1'b0;
        end
    end

endmodule

// File: rtl/sync_ctrl.sv
// Input-synchronizer sequencing controller: flags, arm/disarm, settle blanking, sample strobe.
// Optional divider enabled by defining SYNC_CTRL_DIVIDER_EN; otherwise every RUN cycle strobes.
module sync_ctrl
    import sync_ctrl_pkg::*;
#(
    parameter int DIV_WIDTH     = 24,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_data,
    output logic        enableFilter,
    output logic        enableDemux,
    output logic        falling,
    output logic        run,
    output logic        sample_valid,
    output logic        busy
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] settle_cnt_r;
    logic [2:0] flags_r;
    logic [2:0] flags_nxt_s;
    logic       run_r;
    logic       busy_r;
    logic       accept_s;
    logic       strobe_s;
    logic       unused_data_s;

    assign cmd_ready     = (state_r != ST_SETTLE);
    assign accept_s      = cmd_valid && cmd_ready;
    assign unused_data_s = ^cmd_data;

    assign falling      = flags_r[FLG_FALLING];
    assign enableFilter = flags_r[FLG_FILTER];
    assign enableDemux  = flags_r[FLG_DEMUX];
    assign run          = run_r;
    assign busy         = busy_r;
    assign sample_valid = strobe_s;

    // Next-state and next-flag decode; shared with the divider so its strobe lines up with RUN.
    always_comb begin
        state_nxt_s = state_r;
        flags_nxt_s = flags_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (cmd_op == OP_FLAGS)) begin
                    flags_nxt_s = cmd_data[2:0];
                end else if (accept_s && (cmd_op == OP_ARM)) begin
                    state_nxt_s = ST_SETTLE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_r == 4'd0) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_SETTLE;
                end
            end
            ST_RUN: begin
                if (accept_s && (cmd_op == OP_FLAGS)) begin
                    flags_nxt_s = cmd_data[2:0];
                    if (cmd_data[2:0] != flags_r) begin
                        state_nxt_s = ST_SETTLE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else if (accept_s && (cmd_op == OP_DISARM)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sequencing FSM with its registered status outputs and settle countdown.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            flags_r      <= 3'b000;
            settle_cnt_r <= 4'd0;
            run_r        <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            flags_r <= flags_nxt_s;
            run_r   <= (state_nxt_s != ST_IDLE);
            busy_r  <= (state_nxt_s == ST_SETTLE);
            if ((state_r != ST_SETTLE) && (state_nxt_s == ST_SETTLE)) begin
                settle_cnt_r <= SETTLE_LOAD;
            end else if ((state_r == ST_SETTLE) && (settle_cnt_r != 4'd0)) begin
                settle_cnt_r <= settle_cnt_r - 4'd1;
            end else begin
                settle_cnt_r <= settle_cnt_r;
            end
        end
    end

`ifdef SYNC_CTRL_DIVIDER_EN
    logic [DIV_WIDTH-1:0] div_r;
    logic [DIV_WIDTH-1:0] div_nxt_s;
    logic                 div_wr_s;

    assign div_wr_s  = accept_s && (cmd_op == OP_DIV);
    assign div_nxt_s = div_wr_s ? cmd_data[DIV_WIDTH-1:0] : div_r;

    // Divider register; the divider sees the incoming value on the write cycle itself.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            div_r <= {DIV_WIDTH{1'b0}};
        end else begin
            div_r <= div_nxt_s;
        end
    end

    sample_divider #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_sample_divider (
        .clock  (clock),
        .resetn (resetn),
        .enable (state_nxt_s == ST_RUN),
        .clear  (div_wr_s),
        .div    (div_nxt_s),
        .strobe (strobe_s)
    );
`else
    logic strobe_r;

    assign strobe_s = strobe_r;

    // Without a divider every RUN cycle carries a valid sample.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            strobe_r <= 1'b0;
        end else begin
            strobe_r <= (state_nxt_s == ST_RUN);
        end
    end
`endif

endmodule

// File: tb/tb_sync_ctrl.sv
// Scoreboard bench for sync_ctrl: stimulus pushes per-cycle expected outputs, a monitor pops and compares.
module tb_sync_ctrl;
    import sync_ctrl_pkg::*;

    localparam int S = 3;
`ifdef SYNC_CTRL_DIVIDER_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        enableFilter, enableDemux, falling, run, sample_valid, busy;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic [6:0] exp_q[$];

    // model state: 0 idle, 1 settle, 2 run
    int          m_state = 0;
    int          m_left  = 0;
    logic [2:0]  m_flags = 3'b000;
    logic [23:0] m_div   = 24'd0;
    int unsigned m_p     = 0;

    sync_ctrl #(.DIV_WIDTH(24), .SETTLE_CYCLES(S)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .enableFilter (enableFilter),
        .enableDemux  (enableDemux),
        .falling      (falling),
        .run          (run),
        .sample_valid (sample_valid),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] outs();
        return {cmd_ready, busy, run, sample_valid, enableDemux, enableFilter, falling};
    endfunction

    // monitor: one expected vector per clock edge that had stimulus behind it
    initial begin
        logic [6:0] e;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (outs() !== e) begin
                    n_bad++;
                    $display("FAIL cycle_vec @%0d: got rdy/busy/run/sv/dmx/flt/fal=%b expected %b", cyc, outs(), e);
                end
            end
        end
    end

    task automatic step(input logic v, input logic [1:0] op, input logic [31:0] d);
        int          ns;
        logic        acc;
        logic        sv;
        int unsigned dd;
        @(negedge clock);
        cmd_valid = v;
        cmd_op    = op;
        cmd_data  = d;
        sv        = 1'b0;
        if (!resetn) begin
            m_state = 0; m_left = 0; m_flags = 3'b000; m_div = 24'd0; m_p = 0;
        end else begin
            acc = v && (m_state != 1);
            ns  = m_state;
            if (m_state == 1) begin
                m_left--;
                if (m_left == 0) ns = 2;
            end else if (acc) begin
                case (op)
                    OP_FLAGS: begin
                        if (m_state == 2 && d[2:0] != m_flags) begin
                            ns = 1; m_left = S;
                        end
                        m_flags = d[2:0];
                    end
                    OP_DIV: begin
                        if (DIV_EN) m_div = d[23:0];
                        m_p = 0;
                    end
                    OP_ARM: if (m_state == 0) begin ns = 1; m_left = S; end
                    default: ns = 0;
                endcase
            end
            if (ns == 2) begin
                if (m_state != 2) m_p = 0;
                dd = DIV_EN ? 32'(m_div) : 0;
                sv = ((m_p % (dd + 1)) == dd);
                m_p++;
            end
            m_state = ns;
        end
        exp_q.push_back({m_state != 1, m_state == 1, m_state != 0, sv, m_flags});
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, OP_FLAGS, 32'd0);
    endtask

    task automatic check_reset_outs(input string name);
        n_vec++;
        if (outs() !== 7'b1000000) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, outs(), 7'b1000000);
        end
    endtask

    // arm, then count cycles (arm edge = cycle 0) until the first strobe
    task automatic arm_and_time(input int expected);
        int n;
        step(1'b1, OP_ARM, 32'd0);
        n = 1;
        while (!sample_valid && n < 64) begin
            step(1'b0, OP_FLAGS, 32'd0);
            n++;
        end
        n_vec++;
        if (n != expected) begin
            n_bad++;
            $display("FAIL strobe_latency: got %0d cycles expected %0d", n, expected);
        end
    endtask

    initial begin
        resetn = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 32'd0;
        step(1'b0, OP_FLAGS, 32'd0);
        step(1'b0, OP_FLAGS, 32'd0);
        check_reset_outs("reset_state");
        resetn = 1'b1;
        idle(2);

        // arm with div=0: first strobe in cycle 4, then every cycle
        arm_and_time(4);
        idle(4);
        step(1'b1, OP_DISARM, 32'd0);
        idle(2);

        // div=4: strobe every 5 cycles, first after 3+5
        step(1'b1, OP_DIV, 32'd4);
        arm_and_time(DIV_EN ? 8 : 4);
        idle(12);
        step(1'b1, OP_ARM, 32'd0);          // ignored in RUN
        idle(3);

        // flag change blanks, identical write does not
        step(1'b1, OP_FLAGS, 32'h0000_0002);
        idle(9);
        step(1'b1, OP_FLAGS, 32'h0000_0002);
        idle(9);

        // disarm held through a settle period
        step(1'b1, OP_FLAGS, 32'h0000_0005);
        for (int i = 0; i < 4; i++) step(1'b1, OP_DISARM, 32'd0);
        idle(4);

        // div=7, run, then asynchronous reset mid-RUN
        step(1'b1, OP_DIV, 32'd7);
        step(1'b1, OP_ARM, 32'd0);
        idle(13);
        cmd_valid = 1'b0;
        @(negedge clock);
        #2 resetn = 1'b0;
        #1 check_reset_outs("async_reset");
        step(1'b0, OP_FLAGS, 32'd0);
        step(1'b0, OP_FLAGS, 32'd0);
        resetn = 1'b1;
        idle(1);

        // divider is back to 0 after reset
        arm_and_time(4);
        idle(3);

        repeat (2) @(posedge clock);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
